// File: rtl/pwm_cfg_if.sv
// Configuration and pin-drive bundle between the SPI register file and
// the PWM peripheral. Signal names match the SPI register outputs and the
// pin bus of the top level.
interface pwm_cfg_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  // Register-file side: drives configuration, observes the pins.
  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out,
    input  period_start
  );

  // Peripheral side: consumes configuration, drives the pins.
  modport slave (
    input  en_reg_out_7_0,
    input  en_reg_out_15_8,
    input  en_reg_pwm_7_0,
    input  en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out,
    output period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin is held low, held high, or follows one
// shared PWM waveform. The waveform comes from a prescaled 8-bit counter
// whose duty cycle is shadowed and only reloaded at a period boundary.
// Stage 1 holds the counters and shadow duty; stage 2 registers the pins.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13  // clk cycles per PWM count, 1..65535
) (
  input  logic      clk,
  input  logic      rst_n,
  pwm_cfg_if.slave  cfg_bus
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  // Stage 1 state
  logic [15:0] pre_cnt_q,     pre_cnt_d;
  logic [7:0]  pwm_cnt_q,     pwm_cnt_d;
  logic [7:0]  duty_active_q, duty_active_d;

  // Stage 2 state
  logic [15:0] out_q,          out_d;
  logic        period_start_q, period_start_d;

  logic        tick;
  logic        boundary;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {cfg_bus.en_reg_out_15_8, cfg_bus.en_reg_out_7_0};
  assign en_pwm = {cfg_bus.en_reg_pwm_15_8, cfg_bus.en_reg_pwm_7_0};

  // One count step per PRESCALE cycles; with PRESCALE=1 this is always high.
  assign tick     = (pre_cnt_q == PRE_MAX);
  // Last cycle of the period: the edge that wraps pwm_cnt also reloads the duty.
  assign boundary = tick && (pwm_cnt_q == 8'hFF);

  // Next-state for the prescaler, the PWM counter and the duty shadow.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    pre_cnt_d     = pre_cnt_q + 16'd1;
    pwm_cnt_d     = pwm_cnt_q;
    duty_active_d = duty_active_q;
    if (tick) begin
      pre_cnt_d = '0;
      // 8-bit wrap 255 -> 0 is the natural overflow.
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end
    if (boundary) begin
      duty_active_d = cfg_bus.pwm_duty_cycle;
    end
  end

  // PWM level from the current count and the active duty; 0xFF is full-on.
  always_comb begin
    pwm_level = 1'b0;
    if (duty_active_q == 8'hFF) begin
      pwm_level = 1'b1;
    end else if (duty_active_q != 8'h00) begin
      pwm_level = (pwm_cnt_q < duty_active_q);
    end
  end

  // Per-pin select: disabled -> 0, enabled static -> 1, enabled PWM -> level.
  always_comb begin
    out_d          = en_out & (~en_pwm | {16{pwm_level}});
    period_start_d = (pwm_cnt_q == 8'd0) && (pre_cnt_q == 16'd0);
  end

  // Stage 1 registers: counters and duty shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      duty_active_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, so ordering between registers does not matter.
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_active_q <= duty_active_d;
    end
  end

  // Stage 2 registers: pin drive and period marker, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign cfg_bus.out          = out_q;
  assign cfg_bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral with PRESCALE=2 (512-cycle period). The stimulus
// process queues the expected shape of each PWM period as it configures it;
// a monitor measures every period delimited by period_start and compares.
module tb_pwm_peripheral;

  localparam int PRESCALE = 2;
  localparam int PERIOD   = 256 * PRESCALE;

  typedef struct {
    string name;
    int    len;   // cycles between period_start pulses
    int    hi;    // high cycles of out[0]; -1 = not checked
  } exp_t;

  logic clk;
  logic rst_n;
  pwm_cfg_if cfg_bus ();

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  bit   mon_en = 0;

  pwm_peripheral #(.PRESCALE(PRESCALE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_bus (cfg_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic set_cfg(input logic [15:0] en_out, input logic [15:0] en_pwm,
                         input logic [7:0] duty);
    cfg_bus.en_reg_out_7_0  = en_out[7:0];
    cfg_bus.en_reg_out_15_8 = en_out[15:8];
    cfg_bus.en_reg_pwm_7_0  = en_pwm[7:0];
    cfg_bus.en_reg_pwm_15_8 = en_pwm[15:8];
    cfg_bus.pwm_duty_cycle  = duty;
  endtask

  // Returns at the negedge where period_start is seen, with the cycle count.
  task automatic wait_pulse(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!cfg_bus.period_start && cycles < 2 * PERIOD);
    if (!cfg_bus.period_start) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic push(input string name, input int hi);
    exp_t e;
    e.name = name;
    e.len  = PERIOD;
    e.hi   = hi;
    exp_q.push_back(e);
  endtask

  // Monitor: measures each period between period_start pulses.
  initial begin : monitor
    bit in_period = 0;
    int len = 0, hi = 0;
    bit seen_low = 0, bad_shape = 0, pair_bad = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_period = 0;
      end else if (mon_en) begin
        if (cfg_bus.period_start) begin
          if (in_period) begin
            check("period_expected", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check({e.name, "_len"}, len, e.len);
              if (e.hi >= 0) begin
                check({e.name, "_high"}, hi, e.hi);
                check({e.name, "_high_first"}, bad_shape, 0);
                check({e.name, "_pins_1_0_equal"}, pair_bad, 0);
              end
            end
          end
          in_period = 1;
          len = 0; hi = 0; seen_low = 0; bad_shape = 0; pair_bad = 0;
        end
        if (in_period) begin
          len++;
          if (cfg_bus.out[0]) begin
            hi++;
            if (seen_low) bad_shape = 1;
          end else begin
            seen_low = 1;
          end
          if (cfg_bus.out[1] !== cfg_bus.out[0]) pair_bad = 1;
        end
      end
    end
  end

  // Hard stop so a stuck design cannot hang the run.
  initial begin : watchdog
    #(20 * PERIOD * 10 * 2);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin : stimulus
    int cyc;
    rst_n = 1'b0;
    set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
    repeat (3) @(negedge clk);
    check("reset_out", cfg_bus.out, 16'h0000);
    check("reset_period_start", cfg_bus.period_start, 0);

    rst_n  = 1'b1;
    mon_en = 1;
    wait_pulse("first_pulse", cyc);
    check("first_pulse_cycle", cyc, 1);

    // Period 0: duty_active still 0; static and enable-latency checks.
    push("p0", -1);
    set_cfg(16'h8001, 16'h0000, 8'h00);
    @(negedge clk);
    check("static_8001", cfg_bus.out, 16'h8001);
    set_cfg(16'h0000, 16'h0000, 8'h00);
    @(negedge clk);
    check("static_off", cfg_bus.out, 16'h0000);
    set_cfg(16'h0003, 16'h0003, 8'h40);
    @(negedge clk);
    check("pwm_first_period_low", cfg_bus.out, 16'h0000);

    wait_pulse("p1", cyc);
    push("p1_duty40", 128);
    wait_pulse("p2", cyc);
    push("p2_duty40", 128);
    set_cfg(16'h0003, 16'h0003, 8'h00);
    wait_pulse("p3", cyc);
    push("p3_duty00", 0);
    set_cfg(16'h0003, 16'h0003, 8'hFF);
    wait_pulse("p4", cyc);
    push("p4_dutyFF", PERIOD);
    set_cfg(16'h0003, 16'h0003, 8'h40);
    wait_pulse("p5", cyc);
    push("p5_duty40_midchange", 128);
    repeat (100 * PRESCALE) @(negedge clk);
    set_cfg(16'h0003, 16'h0003, 8'hC0);
    wait_pulse("p6", cyc);
    push("p6_dutyC0", 192 * PRESCALE);
    set_cfg(16'h0003, 16'h0003, 8'h80);

    // Period 7 is cut short by reset at count 30 while out is high.
    wait_pulse("p7", cyc);
    repeat (30 * PRESCALE) @(negedge clk);
    check("pre_reset_out_high", cfg_bus.out, 16'h0003);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", cfg_bus.out, 16'h0000);
    check("async_reset_period_start", cfg_bus.period_start, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse("post_reset_pulse", cyc);
    check("post_reset_pulse_cycle", cyc, 1);
    push("p8_post_reset_low", 0);
    wait_pulse("p9", cyc);
    push("p9_duty80", 128 * PRESCALE);
    wait_pulse("p10", cyc);
    @(negedge clk);
    mon_en = 0;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
